// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES datapath types and FSM encoding
`timescale 1ns/1ps
package aes_pkg;
   typedef logic [7:0]   byte_t;
   typedef logic [127:0] state_t;

   localparam int NB = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } fsm_t;
endpackage

// File: rtl/inv_subbytes_seq_invsbox.sv
// rtl/inv_subbytes_seq_invsbox.sv - combinational AES inverse S-box lane
`timescale 1ns/1ps
module invsbox
   import aes_pkg::*;
(
   input  byte_t value,
   output byte_t image
);
   localparam byte_t TABLE [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   assign image = TABLE[value];
endmodule

// File: rtl/inv_subbytes_seq.sv
// rtl/inv_subbytes_seq.sv - AES InvSubBytes over a 128-bit state, LANES bytes per clock
`timescale 1ns/1ps
module inv_subbytes_seq
   import aes_pkg::*;
#(
   parameter int LANES = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
);
   localparam int NPASS = NB / LANES;
   localparam int CW    = (NPASS > 1) ? $clog2(NPASS) : 1;

   if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
      $error("inv_subbytes_seq: LANES must be 1, 2, 4, 8 or 16");
   end

   fsm_t          state;
   byte_t         buf_q [NB];
   logic [CW-1:0] cnt;
   logic [3:0]    idx [LANES];
   byte_t         lane_in [LANES];
   byte_t         lane_out [LANES];

   // Byte positions handled in the current pass; each lane reads its byte through this mux.
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         idx[l]     = 4'(int'(cnt) * LANES + l);
         lane_in[l] = buf_q[idx[l]];
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      invsbox u_invsbox (
         .value (lane_in[l]),
         .image (lane_out[l])
      );
   end

   always_comb begin
      out_data = '0;
      for (int i = 0; i < NB; i++) begin
         out_data[(NB-1-i)*8 +: 8] = buf_q[i];
      end
   end

   // Combinational out_ready -> in_ready lets a new block enter as the old one leaves.
   assign in_ready = (state == ST_IDLE) | ((state == ST_DONE) & out_ready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         for (int i = 0; i < NB; i++) begin
            buf_q[i] <= '0;
         end
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  for (int i = 0; i < NB; i++) begin
                     buf_q[i] <= in_data[(NB-1-i)*8 +: 8];
                  end
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               for (int l = 0; l < LANES; l++) begin
                  buf_q[idx[l]] <= lane_out[l];
               end
               if (cnt == CW'(NPASS - 1)) begin
                  cnt       <= '0;
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= ST_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (in_valid) begin
                     for (int i = 0; i < NB; i++) begin
                        buf_q[i] <= in_data[(NB-1-i)*8 +: 8];
                     end
                     cnt   <= '0;
                     busy  <= 1'b1;
                     state <= ST_RUN;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: begin
               state     <= ST_IDLE;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_inv_subbytes_seq.sv
// tb/tb_inv_subbytes_seq.sv - self-checking bench for inv_subbytes_seq across all lane counts
`timescale 1ns/1ps
module tb_inv_subbytes_seq;
   import aes_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [4:0] in_valid_v, out_ready_v;
   logic [4:0] in_ready_v, out_valid_v, busy_v;
   state_t     in_data_a [5];
   state_t     out_data_a [5];

   // Instance g uses LANES = 2**g: 1, 2, 4, 8, 16.
   for (genvar g = 0; g < 5; g++) begin : g_dut
      inv_subbytes_seq #(.LANES(1 << g)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid_v[g]),
         .in_ready  (in_ready_v[g]),
         .in_data   (in_data_a[g]),
         .out_valid (out_valid_v[g]),
         .out_ready (out_ready_v[g]),
         .out_data  (out_data_a[g]),
         .busy      (busy_v[g])
      );
   end

   byte_t inv_tab [256];
   int    n_checks = 0;
   int    n_err    = 0;

   function automatic byte_t gmul(input byte_t a_in, input byte_t b_in);
      byte_t a = a_in;
      byte_t b = b_in;
      byte_t p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   // Forward S-box from its definition: GF(2^8) inverse followed by the affine map.
   function automatic byte_t sbox_fwd(input byte_t x);
      byte_t inv = 8'h00;
      byte_t r;
      if (x != 8'h00) begin
         for (int y = 1; y < 256; y++) begin
            if (gmul(x, byte_t'(y)) == 8'h01) inv = byte_t'(y);
         end
      end
      r = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      return r;
   endfunction

   function automatic state_t ref_state(input state_t s);
      state_t r;
      for (int i = 0; i < 16; i++) begin
         r[i*8 +: 8] = inv_tab[s[i*8 +: 8]];
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hand one block to instance k with out_ready high; return result and cycles to out_valid.
   task automatic run_block(input int k, input state_t d, output state_t q, output int lat);
      out_ready_v[k] = 1'b1;
      in_valid_v[k]  = 1'b1;
      in_data_a[k]   = d;
      check($sformatf("in_ready_L%0d", 1 << k), 128'(in_ready_v[k]), 128'd1);
      tick();
      in_valid_v[k] = 1'b0;
      lat = 0;
      while (out_valid_v[k] !== 1'b1 && lat < 100) begin
         tick();
         lat++;
      end
      q = out_data_a[k];
   endtask

   initial begin
      state_t q, d, d2, hold, cur;
      int     lat, sent, recv, cyc;
      logic   pend;
      logic [255:0] seen;
      state_t exp_q [$];

      for (int x = 0; x < 256; x++) inv_tab[sbox_fwd(byte_t'(x))] = byte_t'(x);

      rst         = 1'b1;
      in_valid_v  = '0;
      out_ready_v = '0;
      for (int k = 0; k < 5; k++) in_data_a[k] = '0;
      tick();
      tick();
      check("reset_in_ready", 128'(in_ready_v), 128'h1f);
      check("reset_out_valid", 128'(out_valid_v), 128'h0);
      check("reset_busy", 128'(busy_v), 128'h0);
      rst = 1'b0;
      tick();

      // FIPS-197 style vector and selected entries on the 4-lane instance.
      run_block(2, 128'h000102030405060708090a0b0c0d0e0f, q, lat);
      check("vec_data", q, 128'h52096ad53036a538bf40a39e81f3d7fb);
      check("vec_latency", 128'(lat), 128'd4);
      run_block(2, {16{8'h63}}, q, lat);
      check("all63", q, {16{8'h00}});
      run_block(2, {16{8'h4d}}, q, lat);
      check("all4d", q, {16{8'h65}});
      run_block(2, {16{8'h16}}, q, lat);
      check("all16", q, {16{8'hff}});
      tick();

      // Exhaustive table coverage and latency on every lane count.
      for (int k = 0; k < 5; k++) begin
         seen = '0;
         for (int blk = 0; blk < 16; blk++) begin
            for (int i = 0; i < 16; i++) d[(15-i)*8 +: 8] = byte_t'(blk * 16 + i);
            run_block(k, d, q, lat);
            check($sformatf("exh_L%0d_b%0d", 1 << k, blk), q, ref_state(d));
            check($sformatf("lat_L%0d_b%0d", 1 << k, blk), 128'(lat), 128'(16 >> k));
            for (int i = 0; i < 16; i++) seen[q[i*8 +: 8]] = 1'b1;
         end
         tick();
         check($sformatf("distinct_L%0d", 1 << k), 128'($countones(seen)), 128'd256);
      end

      // Backpressure: stall in DONE, then release with a new block waiting.
      d  = {$urandom(), $urandom(), $urandom(), $urandom()};
      d2 = {$urandom(), $urandom(), $urandom(), $urandom()};
      out_ready_v[2] = 1'b0;
      in_valid_v[2]  = 1'b1;
      in_data_a[2]   = d;
      tick();
      in_data_a[2] = d2;
      lat = 0;
      while (out_valid_v[2] !== 1'b1 && lat < 100) begin
         tick();
         lat++;
      end
      hold = out_data_a[2];
      check("bp_data", hold, ref_state(d));
      for (int c = 0; c < 10; c++) begin
         tick();
         check($sformatf("bp_valid_%0d", c), 128'(out_valid_v[2]), 128'd1);
         check($sformatf("bp_stable_%0d", c), out_data_a[2], hold);
         check($sformatf("bp_in_ready_%0d", c), 128'(in_ready_v[2]), 128'd0);
      end
      out_ready_v[2] = 1'b1;
      #1;
      check("bp_release_in_ready", 128'(in_ready_v[2]), 128'd1);
      tick();
      in_valid_v[2] = 1'b0;
      check("bp_busy_next", 128'(busy_v[2]), 128'd1);
      check("bp_valid_dropped", 128'(out_valid_v[2]), 128'd0);
      lat = 0;
      while (out_valid_v[2] !== 1'b1 && lat < 100) begin
         tick();
         lat++;
      end
      check("bp_second_data", out_data_a[2], ref_state(d2));
      check("bp_second_lat", 128'(lat), 128'd4);
      tick();

      // Asynchronous reset during the second RUN cycle.
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_valid_v[2] = 1'b1;
      in_data_a[2]  = d;
      tick();
      in_valid_v[2] = 1'b0;
      tick();
      check("rst_mid_busy_before", 128'(busy_v[2]), 128'd1);
      #3 rst = 1'b1;
      #1;
      check("rst_async_out_valid", 128'(out_valid_v[2]), 128'd0);
      check("rst_async_busy", 128'(busy_v[2]), 128'd0);
      check("rst_async_in_ready", 128'(in_ready_v[2]), 128'd1);
      #1 rst = 1'b0;
      tick();
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_block(2, d, q, lat);
      check("rst_after_data", q, ref_state(d));
      check("rst_after_lat", 128'(lat), 128'd4);
      tick();

      // Random streaming with random source gaps and sink stalls.
      sent = 0;
      recv = 0;
      cyc  = 0;
      pend = 1'b0;
      cur  = '0;
      while (recv < 1000 && cyc < 40000) begin
         out_ready_v[2] = ($urandom_range(0, 3) != 0);
         if (!pend && sent < 1000 && $urandom_range(0, 2) != 0) begin
            cur  = {$urandom(), $urandom(), $urandom(), $urandom()};
            pend = 1'b1;
         end
         in_valid_v[2] = pend;
         in_data_a[2]  = cur;
         #1;
         if (pend && in_ready_v[2]) begin
            exp_q.push_back(ref_state(cur));
            pend = 1'b0;
            sent++;
         end
         if (out_valid_v[2] && out_ready_v[2]) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_err++;
               $error("FAIL stream_extra observed=%h expected=none", out_data_a[2]);
            end else begin
               check($sformatf("stream_%0d", recv), out_data_a[2], exp_q.pop_front());
            end
            recv++;
         end
         tick();
         cyc++;
      end
      in_valid_v[2] = 1'b0;
      check("stream_recv_count", 128'(recv), 128'd1000);
      check("stream_sent_count", 128'(sent), 128'd1000);
      check("stream_leftover", 128'(exp_q.size()), 128'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
